core_control_unit: RTL and testbench
====================================

# core_control_unit

Multicycle control FSM for the RV32I core: it sequences fetch, execute and memory phases and drives every control strobe and mux select consumed by the datapath. It takes the opcode, funct3, branch condition and memory-complete status from the datapath and memory port. It also owns debug-mode entry and exit: halt, resume, abstract register access and program-buffer execution.

## Interface

- No parameters. Opcode and funct3 widths come from `ISA__OPCODE_WIDTH` (7) and `ISA__FUNCT3_WIDTH` (3).
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- mem_complete  in  1  current memory access finishes this cycle
- opcode  in  7  IR[6:0]
- f3  in  3  IR[14:12]
- branch_cond  in  1  datapath comparator result for f3 on rs1/rs2
- halt_req, resume_req  in  1  debug module requests
- abstract_req, abstract_wr, abstract_postexec  in  1  abstract command valid, write direction, run progbuf after
- halted  out  1  hart in debug halt
- write_pc_ne, write_pc_ex  out  1  PC load from next-sequential / from ALU
- write_pc  out  1  OR of write_pc_ne and write_pc_ex
- write_ir, write_rd, write_csr  out  1  register enables
- mem_read, mem_write  out  1  memory strobes, held until mem_complete
- addr_sel  out  1  0 = ALU, 1 = PC
- rd_sel  out  2  00 = ALU, 01 = MEM, 10 = CSR
- alu_insel1  out  2  00 = RS, 01 = PC, 10 = ZR
- alu_insel2  out  2  00 = RS, 01 = IM, 10 = IS (constant 4)
- abstract_write, abstract_done, progbuf  out  1  abstract GPR write strobe, command-complete pulse, fetch from program buffer

## Operation

- Outputs are Moore/Mealy combinational decode of the state register plus opcode/f3/mem_complete. Every output is 0 in any state or condition not listed below.
- ALU1_PC selects the instruction PC latched by the datapath on write_ir, so jump ordering is hazard-free.
- States:
  - RESET: all outputs 0. Next state is HALTED if halt_req, else FETCH.
  - FETCH: mem_read=1, addr_sel=PC.
    - On mem_complete: write_ir=1 and go to EXEC.
    - Before starting a fetch, if halt_req=1, go to HALTED instead with no strobes.
  - EXEC, by opcode:
    - OP / OP-IMM: RS with RS (OP) or IM (OP-IMM); write_rd=1, write_pc_ne=1; go to FETCH.
    - LUI: ZR+IM. AUIPC: PC+IM. Both write_rd, write_pc_ne, then FETCH.
    - BRANCH: PC+IM. write_pc_ex=branch_cond, write_pc_ne=!branch_cond; then FETCH.
    - JAL / JALR: target PC+IM or RS+IM; write_pc_ex=1; go to LINK.
    - LOAD / STORE: go to MEM with no strobes.
    - SYSTEM with f3≠0: rd_sel=CSR, write_rd=1, write_csr=1, write_pc_ne=1, then FETCH.
    - SYSTEM with f3=0 (ebreak): go to HALTED. If progbuf=1, also pulse abstract_done.
    - MISC-MEM and undefined opcodes: write_pc_ne=1 only (NOP), then FETCH.
  - LINK: ALU1_PC, ALU2_IS, rd_sel=ALU, write_rd=1; then FETCH.
  - MEM: RS+IM, addr_sel=ALU; mem_read (LOAD) or mem_write (STORE).
    - On mem_complete: write_pc_ne=1; LOAD also write_rd=1 with rd_sel=MEM. Then FETCH.
  - HALTED: halted=1, progbuf cleared.
    - resume_req: go to FETCH.
    - Else abstract_req: go to ABSTRACT.
    - resume_req has priority over abstract_req.
  - ABSTRACT: one cycle; halted=1, abstract_write=abstract_wr.
    - abstract_postexec=1: set the progbuf flag and go to FETCH.
    - Else: pulse abstract_done and return to HALTED.
- progbuf flag: set on ABSTRACT→FETCH, cleared on entry to HALTED. halt_req is ignored while progbuf=1.
- Reset mid-operation aborts any access immediately. No strobe survives reset.

## Timing

- Reset values: all outputs 0; state RESET.
- FETCH lasts N cycles, where N is the number of cycles up to and including the mem_complete cycle.
- Instruction latency:
  - ALU, CSR, branch: N+1 cycles.
  - Jumps: N+2 cycles.
  - Load/store: N+1+M cycles, where M is the memory wait.
- halt_req is sampled only at an instruction boundary (FETCH entry). Halt latency after a held halt_req is at most one instruction.
- abstract_done is a single-cycle pulse.
- mem_read and mem_write are never asserted together.

## Configuration

- `CORE_CONTROL_UNIT_DEBUG_EN` defined: full debug behaviour as above.
- Undefined: HALTED, ABSTRACT and the progbuf flag are removed.
  - halted, abstract_write, abstract_done and progbuf are tied to 0.
  - halt_req, resume_req and abstract_* are ignored.
  - RESET always goes to FETCH.
  - ebreak executes as a NOP (write_pc_ne=1).

## Structure

- Shared package `core_pkg`: state enum (RESET, FETCH, EXEC, LINK, MEM, HALTED, ABSTRACT) and instruction-class enum.
- Opcode constants stay in `isa.svh`. Select encodings stay in `control_signals_if.svh`.
- One sub-module: `core_opcode_decoder`, combinational opcode → instruction class, including the illegal/NOP class.

## Test plan

- Reset, then addi with mem_complete on the 2nd fetch cycle → write_ir at cycle 2, then EXEC with write_rd, write_pc_ne, alu_insel2=IM; back to FETCH.
- beq with branch_cond=1 → EXEC asserts write_pc_ex only. With branch_cond=0 → write_pc_ne only.
- jalr → EXEC write_pc_ex with alu1=RS, alu2=IM; then LINK write_rd with alu1=PC, alu2=IS; total N+2 cycles.
- lw with memory wait 3 → MEM holds mem_read and addr_sel=ALU for 3 cycles; the last cycle has write_rd, rd_sel=MEM, write_pc_ne.
- halt_req during a load → load completes, halted=1 next instruction boundary. abstract_req with abstract_wr=1 → one abstract_write cycle and an abstract_done pulse.
- abstract_postexec=1 → progbuf=1 fetch; ebreak → abstract_done pulse, HALTED, progbuf=0. resume_req → FETCH with halted=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit:
// ISA field widths, opcodes, datapath select codes, FSM states and instruction classes.
package core_pkg;

  localparam int ISA__OPCODE_WIDTH = 7;
  localparam int ISA__FUNCT3_WIDTH = 3;

  localparam logic [ISA__OPCODE_WIDTH-1:0] OPC_LOAD     = 7'b0000011;
  localparam logic [ISA__OPCODE_WIDTH-1:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [ISA__OPCODE_WIDTH-1:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [ISA__OPCODE_WIDTH-1:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [ISA__OPCODE_WIDTH-1:0] OPC_STORE    = 7'b0100011;
  localparam logic [ISA__OPCODE_WIDTH-1:0] OPC_OP       = 7'b0110011;
  localparam logic [ISA__OPCODE_WIDTH-1:0] OPC_LUI      = 7'b0110111;
  localparam logic [ISA__OPCODE_WIDTH-1:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [ISA__OPCODE_WIDTH-1:0] OPC_JALR     = 7'b1100111;
  localparam logic [ISA__OPCODE_WIDTH-1:0] OPC_JAL      = 7'b1101111;
  localparam logic [ISA__OPCODE_WIDTH-1:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic       ADDR_SEL_ALU = 1'b0;
  localparam logic       ADDR_SEL_PC  = 1'b1;
  localparam logic [1:0] RD_SEL_ALU   = 2'b00;
  localparam logic [1:0] RD_SEL_MEM   = 2'b01;
  localparam logic [1:0] RD_SEL_CSR   = 2'b10;
  localparam logic [1:0] ALU1_RS      = 2'b00;
  localparam logic [1:0] ALU1_PC      = 2'b01;
  localparam logic [1:0] ALU1_ZR      = 2'b10;
  localparam logic [1:0] ALU2_RS      = 2'b00;
  localparam logic [1:0] ALU2_IM      = 2'b01;
  localparam logic [1:0] ALU2_IS      = 2'b10;

  typedef enum logic [2:0] {
    RESET,
    FETCH,
    EXEC,
    LINK,
    MEM,
    HALTED,
    ABSTRACT
  } state_t;

  typedef enum logic [3:0] {
    CLS_OP,
    CLS_OP_IMM,
    CLS_LUI,
    CLS_AUIPC,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LOAD,
    CLS_STORE,
    CLS_SYSTEM,
    CLS_NOP
  } instr_class_t;

endpackage

// File: rtl/core_control_unit_if.sv
// Control unit <-> datapath/memory/debug-module signal bundle.
// master = control unit, slave = datapath side.
interface core_control_unit_if;
  import core_pkg::*;

  logic                         mem_complete;
  logic [ISA__OPCODE_WIDTH-1:0] opcode;
  logic [ISA__FUNCT3_WIDTH-1:0] f3;
  logic                         branch_cond;
  logic                         halt_req;
  logic                         resume_req;
  logic                         abstract_req;
  logic                         abstract_wr;
  logic                         abstract_postexec;

  logic       halted;
  logic       write_pc_ne;
  logic       write_pc_ex;
  logic       write_pc;
  logic       write_ir;
  logic       write_rd;
  logic       write_csr;
  logic       mem_read;
  logic       mem_write;
  logic       addr_sel;
  logic [1:0] rd_sel;
  logic [1:0] alu_insel1;
  logic [1:0] alu_insel2;
  logic       abstract_write;
  logic       abstract_done;
  logic       progbuf;

  modport master (
    input  mem_complete, opcode, f3, branch_cond,
    input  halt_req, resume_req, abstract_req, abstract_wr, abstract_postexec,
    output halted, write_pc_ne, write_pc_ex, write_pc, write_ir, write_rd, write_csr,
    output mem_read, mem_write, addr_sel, rd_sel, alu_insel1, alu_insel2,
    output abstract_write, abstract_done, progbuf
  );

  modport slave (
    output mem_complete, opcode, f3, branch_cond,
    output halt_req, resume_req, abstract_req, abstract_wr, abstract_postexec,
    input  halted, write_pc_ne, write_pc_ex, write_pc, write_ir, write_rd, write_csr,
    input  mem_read, mem_write, addr_sel, rd_sel, alu_insel1, alu_insel2,
    input  abstract_write, abstract_done, progbuf
  );

endinterface

// File: rtl/core_opcode_decoder.sv
// Combinational opcode -> instruction class; MISC-MEM and unknown opcodes fold into CLS_NOP.
module core_opcode_decoder
  import core_pkg::*;
(
  input  logic [ISA__OPCODE_WIDTH-1:0] opcode,
  output instr_class_t                 instr_class
);

  always_comb begin
    instr_class = CLS_NOP;
    case (opcode)
      OPC_OP:       instr_class = CLS_OP;
      OPC_OP_IMM:   instr_class = CLS_OP_IMM;
      OPC_LUI:      instr_class = CLS_LUI;
      OPC_AUIPC:    instr_class = CLS_AUIPC;
      OPC_BRANCH:   instr_class = CLS_BRANCH;
      OPC_JAL:      instr_class = CLS_JAL;
      OPC_JALR:     instr_class = CLS_JALR;
      OPC_LOAD:     instr_class = CLS_LOAD;
      OPC_STORE:    instr_class = CLS_STORE;
      OPC_SYSTEM:   instr_class = CLS_SYSTEM;
      OPC_MISC_MEM: instr_class = CLS_NOP;
      default:      instr_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/core_control_unit.sv
// Multicycle RV32I control FSM: fetch/exec/link/mem sequencing plus debug halt.
// Define CORE_CONTROL_UNIT_DEBUG_EN to build halt, abstract command and program-buffer support.
module core_control_unit
  import core_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  core_control_unit_if.master bus
);

  state_t       state_reg;
  state_t       state_next;
  state_t       boundary_state;
  instr_class_t instr_class;

  core_opcode_decoder u_decoder (
    .opcode      (bus.opcode),
    .instr_class (instr_class)
  );

`ifdef CORE_CONTROL_UNIT_DEBUG_EN
  logic progbuf_reg;
  // halt_req is honoured only between instructions, and never inside the program buffer
  assign boundary_state = (bus.halt_req && !progbuf_reg) ? HALTED : FETCH;
  assign bus.progbuf    = progbuf_reg;
`else
  logic unused_debug_inputs;
  assign unused_debug_inputs = ^{bus.halt_req, bus.resume_req, bus.abstract_req,
                                 bus.abstract_wr, bus.abstract_postexec};
  assign boundary_state = FETCH;
  assign bus.progbuf    = 1'b0;
`endif

  assign bus.write_pc = bus.write_pc_ne | bus.write_pc_ex;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RESET;
`ifdef CORE_CONTROL_UNIT_DEBUG_EN
      progbuf_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
`ifdef CORE_CONTROL_UNIT_DEBUG_EN
      if (state_next == HALTED) begin
        progbuf_reg <= 1'b0;
      end else if (state_reg == ABSTRACT && bus.abstract_postexec) begin
        progbuf_reg <= 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_next         = state_reg;
    bus.halted         = 1'b0;
    bus.write_pc_ne    = 1'b0;
    bus.write_pc_ex    = 1'b0;
    bus.write_ir       = 1'b0;
    bus.write_rd       = 1'b0;
    bus.write_csr      = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.addr_sel       = ADDR_SEL_ALU;
    bus.rd_sel         = RD_SEL_ALU;
    bus.alu_insel1     = ALU1_RS;
    bus.alu_insel2     = ALU2_RS;
    bus.abstract_write = 1'b0;
    bus.abstract_done  = 1'b0;

    case (state_reg)
      RESET: state_next = boundary_state;

      FETCH: begin
        bus.mem_read = 1'b1;
        bus.addr_sel = ADDR_SEL_PC;
        if (bus.mem_complete) begin
          bus.write_ir = 1'b1;
          state_next   = EXEC;
        end
      end

      EXEC: begin
        state_next = boundary_state;
        case (instr_class)
          CLS_OP: begin
            bus.write_rd    = 1'b1;
            bus.write_pc_ne = 1'b1;
          end
          CLS_OP_IMM: begin
            bus.alu_insel2  = ALU2_IM;
            bus.write_rd    = 1'b1;
            bus.write_pc_ne = 1'b1;
          end
          CLS_LUI: begin
            bus.alu_insel1  = ALU1_ZR;
            bus.alu_insel2  = ALU2_IM;
            bus.write_rd    = 1'b1;
            bus.write_pc_ne = 1'b1;
          end
          CLS_AUIPC: begin
            bus.alu_insel1  = ALU1_PC;
            bus.alu_insel2  = ALU2_IM;
            bus.write_rd    = 1'b1;
            bus.write_pc_ne = 1'b1;
          end
          CLS_BRANCH: begin
            bus.alu_insel1  = ALU1_PC;
            bus.alu_insel2  = ALU2_IM;
            bus.write_pc_ex = bus.branch_cond;
            bus.write_pc_ne = !bus.branch_cond;
          end
          CLS_JAL: begin
            bus.alu_insel1  = ALU1_PC;
            bus.alu_insel2  = ALU2_IM;
            bus.write_pc_ex = 1'b1;
            state_next      = LINK;
          end
          CLS_JALR: begin
            bus.alu_insel2  = ALU2_IM;
            bus.write_pc_ex = 1'b1;
            state_next      = LINK;
          end
          CLS_LOAD, CLS_STORE: state_next = MEM;
          CLS_SYSTEM: begin
            if (bus.f3 != '0) begin
              bus.rd_sel      = RD_SEL_CSR;
              bus.write_rd    = 1'b1;
              bus.write_csr   = 1'b1;
              bus.write_pc_ne = 1'b1;
            end else begin
`ifdef CORE_CONTROL_UNIT_DEBUG_EN
              // ebreak closing a program-buffer run completes the abstract command
              bus.abstract_done = progbuf_reg;
              state_next        = HALTED;
`else
              bus.write_pc_ne = 1'b1;
`endif
            end
          end
          default: bus.write_pc_ne = 1'b1;
        endcase
      end

      // Link uses the PC latched at write_ir, so the earlier PC load cannot disturb it
      LINK: begin
        bus.alu_insel1 = ALU1_PC;
        bus.alu_insel2 = ALU2_IS;
        bus.write_rd   = 1'b1;
        state_next     = boundary_state;
      end

      MEM: begin
        bus.alu_insel2 = ALU2_IM;
        bus.mem_read   = (instr_class == CLS_LOAD);
        bus.mem_write  = (instr_class != CLS_LOAD);
        if (bus.mem_complete) begin
          bus.write_pc_ne = 1'b1;
          if (instr_class == CLS_LOAD) begin
            bus.write_rd = 1'b1;
            bus.rd_sel   = RD_SEL_MEM;
          end
          state_next = boundary_state;
        end
      end

`ifdef CORE_CONTROL_UNIT_DEBUG_EN
      HALTED: begin
        bus.halted = 1'b1;
        if (bus.resume_req) begin
          state_next = FETCH;
        end else if (bus.abstract_req) begin
          state_next = ABSTRACT;
        end
      end

      ABSTRACT: begin
        bus.halted         = 1'b1;
        bus.abstract_write = bus.abstract_wr;
        if (bus.abstract_postexec) begin
          state_next = FETCH;
        end else begin
          bus.abstract_done = 1'b1;
          state_next        = HALTED;
        end
      end
`endif

      default: state_next = RESET;
    endcase
  end

endmodule

// File: tb/tb_core_control_unit.sv
// Directed cycle-by-cycle bench for core_control_unit; debug scenarios follow CORE_CONTROL_UNIT_DEBUG_EN.
module tb_core_control_unit;

  // RV32I major opcodes
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_FENCE  = 7'b0001111;
  localparam logic [6:0] T_OPI    = 7'b0010011;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_SYSTEM = 7'b1110011;

  // Stimulus word: {opcode[16:10], f3[9:7], mc, bc, halt, resume, areq, awr, apost}
  localparam logic [16:0] S_NONE = 17'd0;
  localparam logic [16:0] S_MC   = 17'd1 << 6;
  localparam logic [16:0] S_BC   = 17'd1 << 5;
  localparam logic [16:0] S_HR   = 17'd1 << 4;
  localparam logic [16:0] S_RR   = 17'd1 << 3;
  localparam logic [16:0] S_AR   = 17'd1 << 2;
  localparam logic [16:0] S_AW   = 17'd1 << 1;
  localparam logic [16:0] S_AP   = 17'd1;

  // Observed output word bit masks
  localparam logic [18:0] M_NONE  = 19'd0;
  localparam logic [18:0] M_PB    = 19'd1 << 0;
  localparam logic [18:0] M_AD    = 19'd1 << 1;
  localparam logic [18:0] M_AW    = 19'd1 << 2;
  localparam logic [18:0] M_A2_IM = 19'd1 << 3;
  localparam logic [18:0] M_A2_IS = 19'd2 << 3;
  localparam logic [18:0] M_A1_PC = 19'd1 << 5;
  localparam logic [18:0] M_A1_ZR = 19'd2 << 5;
  localparam logic [18:0] M_RDMEM = 19'd1 << 7;
  localparam logic [18:0] M_RDCSR = 19'd2 << 7;
  localparam logic [18:0] M_APC   = 19'd1 << 9;
  localparam logic [18:0] M_MW    = 19'd1 << 10;
  localparam logic [18:0] M_MR    = 19'd1 << 11;
  localparam logic [18:0] M_WCSR  = 19'd1 << 12;
  localparam logic [18:0] M_WRD   = 19'd1 << 13;
  localparam logic [18:0] M_WIR   = 19'd1 << 14;
  localparam logic [18:0] M_WPC   = 19'd1 << 15;
  localparam logic [18:0] M_PCEX  = 19'd1 << 16;
  localparam logic [18:0] M_PCNE  = 19'd1 << 17;
  localparam logic [18:0] M_HLT   = 19'd1 << 18;
  localparam logic [18:0] MRP     = M_MR | M_APC;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [18:0] obs;

  core_control_unit_if bus ();

  core_control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign obs = {bus.halted, bus.write_pc_ne, bus.write_pc_ex, bus.write_pc, bus.write_ir,
                bus.write_rd, bus.write_csr, bus.mem_read, bus.mem_write, bus.addr_sel,
                bus.rd_sel, bus.alu_insel1, bus.alu_insel2, bus.abstract_write,
                bus.abstract_done, bus.progbuf};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] ins(input logic [6:0] op, input logic [2:0] fn);
    return {op, fn, 7'b0};
  endfunction

  task automatic drive(input logic [16:0] st);
    bus.opcode            = st[16:10];
    bus.f3                = st[9:7];
    bus.mem_complete      = st[6];
    bus.branch_cond       = st[5];
    bus.halt_req          = st[4];
    bus.resume_req        = st[3];
    bus.abstract_req      = st[2];
    bus.abstract_wr       = st[1];
    bus.abstract_postexec = st[0];
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later
  task automatic step(input logic [16:0] st);
    @(negedge clk);
    drive(st);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive(ins(T_LOAD, 3'd2) | S_MC);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (obs !== M_NONE) begin
      failures++;
      $display("FAIL reset_hold: got %05h expected %05h", obs, M_NONE);
    end else $display("ok   reset_hold obs=%05h", obs);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== M_NONE) begin
      failures++;
      $display("FAIL reset_state: got %05h expected %05h", obs, M_NONE);
    end else $display("ok   reset_state obs=%05h", obs);
  endtask

  task automatic test_alu();
    logic [16:0] st [9];
    logic [18:0] ex [9];
    logic [16:0] addi, add, lui, auipc;
    addi  = ins(T_OPI, 3'd0);
    add   = ins(T_OP, 3'd0);
    lui   = ins(T_LUI, 3'd0);
    auipc = ins(T_AUIPC, 3'd0);
    st = '{addi, addi | S_MC, addi, add | S_MC, add, lui | S_MC, lui, auipc | S_MC, auipc};
    ex = '{MRP, MRP | M_WIR, M_WRD | M_PCNE | M_WPC | M_A2_IM,
           MRP | M_WIR, M_WRD | M_PCNE | M_WPC,
           MRP | M_WIR, M_A1_ZR | M_A2_IM | M_WRD | M_PCNE | M_WPC,
           MRP | M_WIR, M_A1_PC | M_A2_IM | M_WRD | M_PCNE | M_WPC};
    for (int i = 0; i < 9; i++) begin
      step(st[i]);
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL alu[%0d]: got %05h expected %05h", i, obs, ex[i]);
      end else $display("ok   alu[%0d] obs=%05h", i, obs);
    end
  endtask

  task automatic test_branch();
    logic [16:0] st [4];
    logic [18:0] ex [4];
    logic [16:0] beq;
    beq = ins(T_BRANCH, 3'd0);
    st = '{beq | S_MC | S_BC, beq | S_BC, beq | S_MC, beq};
    ex = '{MRP | M_WIR, M_A1_PC | M_A2_IM | M_PCEX | M_WPC,
           MRP | M_WIR, M_A1_PC | M_A2_IM | M_PCNE | M_WPC};
    for (int i = 0; i < 4; i++) begin
      step(st[i]);
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL branch[%0d]: got %05h expected %05h", i, obs, ex[i]);
      end else $display("ok   branch[%0d] obs=%05h", i, obs);
    end
  endtask

  task automatic test_jump();
    logic [16:0] st [7];
    logic [18:0] ex [7];
    logic [16:0] jalr, jal;
    jalr = ins(T_JALR, 3'd0);
    jal  = ins(T_JAL, 3'd0);
    st = '{jalr | S_MC, jalr, jalr, jal, jal | S_MC, jal, jal};
    ex = '{MRP | M_WIR, M_A2_IM | M_PCEX | M_WPC, M_A1_PC | M_A2_IS | M_WRD, MRP,
           MRP | M_WIR, M_A1_PC | M_A2_IM | M_PCEX | M_WPC, M_A1_PC | M_A2_IS | M_WRD};
    for (int i = 0; i < 7; i++) begin
      step(st[i]);
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL jump[%0d]: got %05h expected %05h", i, obs, ex[i]);
      end else $display("ok   jump[%0d] obs=%05h", i, obs);
    end
  endtask

  task automatic test_mem();
    logic [16:0] st [10];
    logic [18:0] ex [10];
    logic [16:0] lw, sw;
    lw = ins(T_LOAD, 3'd2);
    sw = ins(T_STORE, 3'd2);
    st = '{lw | S_MC, lw, lw, lw, lw | S_MC, sw, sw | S_MC, sw, sw, sw | S_MC};
    ex = '{MRP | M_WIR, M_NONE, M_MR | M_A2_IM, M_MR | M_A2_IM,
           M_MR | M_A2_IM | M_WRD | M_RDMEM | M_PCNE | M_WPC, MRP,
           MRP | M_WIR, M_NONE, M_MW | M_A2_IM, M_MW | M_A2_IM | M_PCNE | M_WPC};
    for (int i = 0; i < 10; i++) begin
      step(st[i]);
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL mem[%0d]: got %05h expected %05h", i, obs, ex[i]);
      end else $display("ok   mem[%0d] obs=%05h", i, obs);
    end
  endtask

  task automatic test_system();
    logic [16:0] st [6];
    logic [18:0] ex [6];
    logic [16:0] csr, fence, bad;
    csr   = ins(T_SYSTEM, 3'd1);
    fence = ins(T_FENCE, 3'd0);
    bad   = ins(7'b1111111, 3'd0);
    st = '{csr | S_MC, csr, fence | S_MC, fence, bad | S_MC, bad};
    ex = '{MRP | M_WIR, M_RDCSR | M_WRD | M_WCSR | M_PCNE | M_WPC,
           MRP | M_WIR, M_PCNE | M_WPC, MRP | M_WIR, M_PCNE | M_WPC};
    for (int i = 0; i < 6; i++) begin
      step(st[i]);
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL system[%0d]: got %05h expected %05h", i, obs, ex[i]);
      end else $display("ok   system[%0d] obs=%05h", i, obs);
    end
  endtask

`ifdef CORE_CONTROL_UNIT_DEBUG_EN
  task automatic test_halt();
    logic [16:0] st [8];
    logic [18:0] ex [8];
    logic [16:0] lw;
    lw = ins(T_LOAD, 3'd2);
    st = '{lw | S_MC, lw | S_HR, lw | S_HR | S_MC, S_HR, S_NONE, S_AR | S_AW, S_AW, S_NONE};
    ex = '{MRP | M_WIR, M_NONE, M_MR | M_A2_IM | M_WRD | M_RDMEM | M_PCNE | M_WPC,
           M_HLT, M_HLT, M_HLT, M_HLT | M_AW | M_AD, M_HLT};
    for (int i = 0; i < 8; i++) begin
      step(st[i]);
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL halt[%0d]: got %05h expected %05h", i, obs, ex[i]);
      end else $display("ok   halt[%0d] obs=%05h", i, obs);
    end
  endtask

  task automatic test_progbuf();
    logic [16:0] st [9];
    logic [18:0] ex [9];
    logic [16:0] addi, ebrk;
    addi = ins(T_OPI, 3'd0);
    ebrk = ins(T_SYSTEM, 3'd0);
    st = '{S_AR | S_AP, S_AP, addi | S_MC | S_HR, addi | S_HR, ebrk | S_MC | S_HR,
           ebrk | S_HR, S_HR, S_RR | S_AR, S_NONE};
    ex = '{M_HLT, M_HLT, MRP | M_WIR | M_PB, M_WRD | M_PCNE | M_WPC | M_A2_IM | M_PB,
           MRP | M_WIR | M_PB, M_PB | M_AD, M_HLT, M_HLT, MRP};
    for (int i = 0; i < 9; i++) begin
      step(st[i]);
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL progbuf[%0d]: got %05h expected %05h", i, obs, ex[i]);
      end else $display("ok   progbuf[%0d] obs=%05h", i, obs);
    end
  endtask
`else
  task automatic test_no_debug();
    logic [16:0] st [3];
    logic [18:0] ex [3];
    logic [16:0] ebrk;
    ebrk = ins(T_SYSTEM, 3'd0) | S_HR | S_RR | S_AR | S_AW | S_AP;
    st = '{ebrk | S_MC, ebrk, ebrk};
    ex = '{MRP | M_WIR, M_PCNE | M_WPC, MRP};
    for (int i = 0; i < 3; i++) begin
      step(st[i]);
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL no_debug[%0d]: got %05h expected %05h", i, obs, ex[i]);
      end else $display("ok   no_debug[%0d] obs=%05h", i, obs);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [16:0] st [3];
    logic [18:0] ex [3];
    logic [16:0] sw;
    sw = ins(T_STORE, 3'd2);
    st = '{sw | S_MC, sw, sw};
    ex = '{MRP | M_WIR, M_NONE, M_MW | M_A2_IM};
    for (int i = 0; i < 3; i++) begin
      step(st[i]);
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL reset_mid[%0d]: got %05h expected %05h", i, obs, ex[i]);
      end else $display("ok   reset_mid[%0d] obs=%05h", i, obs);
    end
    @(negedge clk);
    drive(sw | S_MC);
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== M_NONE) begin
      failures++;
      $display("FAIL reset_mid_abort: got %05h expected %05h", obs, M_NONE);
    end else $display("ok   reset_mid_abort obs=%05h", obs);
    @(negedge clk);
    rst_n = 1'b1;
    drive(S_NONE);
    #1;
    checks++;
    if (obs !== M_NONE) begin
      failures++;
      $display("FAIL reset_mid_state: got %05h expected %05h", obs, M_NONE);
    end else $display("ok   reset_mid_state obs=%05h", obs);
    step(S_NONE);
    checks++;
    if (obs !== MRP) begin
      failures++;
      $display("FAIL reset_mid_fetch: got %05h expected %05h", obs, MRP);
    end else $display("ok   reset_mid_fetch obs=%05h", obs);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_alu();
    test_branch();
    test_jump();
    test_mem();
    test_system();
`ifdef CORE_CONTROL_UNIT_DEBUG_EN
    test_halt();
    test_progbuf();
`else
    test_no_debug();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
